// File: rtl/sc_serialtx.sv
// sc_serialtx -- asynchronous serial transmitter for the output register value.
//
// Sends DATAWIDTH bits as a frame of 1 start bit (0), the data bits LSB first
// and 1 stop bit (1). Every bit lasts CLKS_PER_BIT clocks. A frame is started
// by an active-low send request that must first have been seen high (arming),
// so a send held low produces exactly one frame.
//
// Ports:
//   SC_SERIALTX_CLOCK_50      in   system clock, rising edge
//   SC_SERIALTX_RESET_InHigh  in   synchronous active-high reset
//   SC_SERIALTX_data_InBUS    in   value to transmit, captured at frame start
//   SC_SERIALTX_send_InLow    in   active-low send request
//   SC_SERIALTX_tx_Out        out  serial line, idle high, driven from a flop
//   SC_SERIALTX_busy_Out      out  high while a frame is on the line
//   SC_SERIALTX_done_Out      out  one-cycle pulse after the last stop-bit cycle
module sc_serialtx #(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 SC_SERIALTX_CLOCK_50,
  input  logic                 SC_SERIALTX_RESET_InHigh,
  input  logic [DATAWIDTH-1:0] SC_SERIALTX_data_InBUS,
  input  logic                 SC_SERIALTX_send_InLow,
  output logic                 SC_SERIALTX_tx_Out,
  output logic                 SC_SERIALTX_busy_Out,
  output logic                 SC_SERIALTX_done_Out
);

  localparam int TIMERW = $clog2(CLKS_PER_BIT);
  localparam int IDXW   = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  localparam logic [TIMERW-1:0] TIMER_ZERO = TIMERW'(0);
  localparam logic [TIMERW-1:0] TIMER_ONE  = TIMERW'(1);
  localparam logic [TIMERW-1:0] TIMER_LAST = TIMERW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0]   INDEX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0]   INDEX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0]   INDEX_LAST = IDXW'(DATAWIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]           state_r,   stateNext_s;
  logic [TIMERW-1:0]    timer_r,   timerNext_s;
  logic [IDXW-1:0]      bitIndex_r, bitIndexNext_s;
  logic [DATAWIDTH-1:0] shift_r,   shiftNext_s;
  logic                 armed_r,   armedNext_s;
  logic                 tx_r,      txNext_s;
  logic                 busy_r,    busyNext_s;
  logic                 done_r,    doneNext_s;

  logic                 bitEnd_s;
  logic                 frameStart_s;
  logic [DATAWIDTH-1:0] shifted_s;

  assign bitEnd_s     = (timer_r == TIMER_LAST);
  assign frameStart_s = (state_r == ST_IDLE) && !SC_SERIALTX_send_InLow && armed_r;
  assign shifted_s    = shift_r >> 1;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    stateNext_s    = state_r;
    timerNext_s    = timer_r;
    bitIndexNext_s = bitIndex_r;
    shiftNext_s    = shift_r;
    txNext_s       = tx_r;
    busyNext_s     = busy_r;
    doneNext_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (frameStart_s) begin
          shiftNext_s = SC_SERIALTX_data_InBUS;
          stateNext_s = ST_START;
          busyNext_s  = 1'b1;
          txNext_s    = 1'b0;
          timerNext_s = TIMER_ZERO;
        end else begin
          txNext_s   = 1'b1;
          busyNext_s = 1'b0;
        end
      end
      ST_START: begin
        if (bitEnd_s) begin
          stateNext_s    = ST_DATA;
          timerNext_s    = TIMER_ZERO;
          bitIndexNext_s = INDEX_ZERO;
          txNext_s       = shift_r[0];
        end else begin
          timerNext_s = timer_r + TIMER_ONE;
        end
      end
      ST_DATA: begin
        if (bitEnd_s) begin
          timerNext_s = TIMER_ZERO;
          shiftNext_s = shifted_s;
          if (bitIndex_r == INDEX_LAST) begin
            stateNext_s    = ST_STOP;
            bitIndexNext_s = INDEX_ZERO;
            txNext_s       = 1'b1;
          end else begin
            bitIndexNext_s = bitIndex_r + INDEX_ONE;
            // Next bit is the new LSB after the shift.
            txNext_s       = shifted_s[0];
          end
        end else begin
          timerNext_s = timer_r + TIMER_ONE;
        end
      end
      ST_STOP: begin
        if (bitEnd_s) begin
          stateNext_s = ST_IDLE;
          timerNext_s = TIMER_ZERO;
          busyNext_s  = 1'b0;
          doneNext_s  = 1'b1;
          txNext_s    = 1'b1;
        end else begin
          timerNext_s = timer_r + TIMER_ONE;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
        timerNext_s = TIMER_ZERO;
        txNext_s    = 1'b1;
        busyNext_s  = 1'b0;
      end
    endcase
  end

  // Arming: any high sample of send re-arms; starting a frame consumes the arm.
  always_comb begin
    armedNext_s = armed_r;
    if (SC_SERIALTX_send_InLow) begin
      armedNext_s = 1'b1;
    end else if (frameStart_s) begin
      armedNext_s = 1'b0;
    end else begin
      armedNext_s = armed_r;
    end
  end

  // State registers with synchronous reset; reset abandons any frame silently.
  always_ff @(posedge SC_SERIALTX_CLOCK_50) begin
    if (SC_SERIALTX_RESET_InHigh) begin
      state_r    <= ST_IDLE;
      timer_r    <= TIMER_ZERO;
      bitIndex_r <= INDEX_ZERO;
      shift_r    <= {DATAWIDTH{1'b0}};
      armed_r    <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      timer_r    <= timerNext_s;
      bitIndex_r <= bitIndexNext_s;
      shift_r    <= shiftNext_s;
      armed_r    <= armedNext_s;
      tx_r       <= txNext_s;
      busy_r     <= busyNext_s;
      done_r     <= doneNext_s;
    end
  end

  assign SC_SERIALTX_tx_Out   = tx_r;
  assign SC_SERIALTX_busy_Out = busy_r;
  assign SC_SERIALTX_done_Out = done_r;

endmodule

// File: tb/tb_sc_serialtx.sv
// Bench for sc_serialtx: two instances (4 and 2 clocks per bit) checked every
// cycle against a frame-level reference model, plus directed scenario checks.
module tb_sc_serialtx;

  localparam int DW   = 8;
  localparam int CPBA = 4;
  localparam int CPBB = 2;
  localparam int FLA  = (DW + 2) * CPBA;
  localparam int FLB  = (DW + 2) * CPBB;

  logic clk = 1'b0;
  // Free-running clock.
  always #5 clk = ~clk;

  logic          rstA, sendA, txA, busyA, doneA;
  logic [DW-1:0] dataA;
  logic          rstB, sendB, txB, busyB, doneB;
  logic [DW-1:0] dataB;

  sc_serialtx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPBA)) uA (
    .SC_SERIALTX_CLOCK_50    (clk),
    .SC_SERIALTX_RESET_InHigh(rstA),
    .SC_SERIALTX_data_InBUS  (dataA),
    .SC_SERIALTX_send_InLow  (sendA),
    .SC_SERIALTX_tx_Out      (txA),
    .SC_SERIALTX_busy_Out    (busyA),
    .SC_SERIALTX_done_Out    (doneA)
  );

  sc_serialtx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPBB)) uB (
    .SC_SERIALTX_CLOCK_50    (clk),
    .SC_SERIALTX_RESET_InHigh(rstB),
    .SC_SERIALTX_data_InBUS  (dataB),
    .SC_SERIALTX_send_InLow  (sendB),
    .SC_SERIALTX_tx_Out      (txB),
    .SC_SERIALTX_busy_Out    (busyB),
    .SC_SERIALTX_done_Out    (doneB)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame position counter (-1 = idle) and the whole frame
  // as a bit vector {stop, data, start}; line level = frame[pos / cpb].
  int          mCnt   [2];
  logic [DW+1:0] mFrame [2];
  logic        mArmed [2];
  logic        mDone  [2];

  int busyCntA, doneCntA, busyCntB, doneCntB;

  task automatic modelEdge(input int i, input logic rst, input logic send,
                           input logic [DW-1:0] data, input int fl);
    bit started;
    started = 1'b0;
    if (rst) begin
      mCnt[i]   = -1;
      mArmed[i] = 1'b0;
      mDone[i]  = 1'b0;
    end else begin
      mDone[i] = 1'b0;
      if (mCnt[i] >= 0) begin
        mCnt[i]++;
        if (mCnt[i] == fl) begin
          mCnt[i]  = -1;
          mDone[i] = 1'b1;
        end
      end else if (!send && mArmed[i]) begin
        mFrame[i] = {1'b1, data, 1'b0};
        mCnt[i]   = 0;
        started   = 1'b1;
      end
      if (send) mArmed[i] = 1'b1;
      else if (started) mArmed[i] = 1'b0;
    end
  endtask

  function automatic logic expTx(input int i, input int cpb);
    if (mCnt[i] >= 0) return mFrame[i][mCnt[i] / cpb];
    else return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance model with the inputs the DUTs sample, compare at negedge.
  task automatic cycle();
    @(posedge clk);
    modelEdge(0, rstA, sendA, dataA, FLA);
    modelEdge(1, rstB, sendB, dataB, FLB);
    @(negedge clk);
    chk("txA",   txA,   expTx(0, CPBA));
    chk("busyA", busyA, (mCnt[0] >= 0));
    chk("doneA", doneA, mDone[0]);
    chk("txB",   txB,   expTx(1, CPBB));
    chk("busyB", busyB, (mCnt[1] >= 0));
    chk("doneB", doneB, mDone[1]);
    if (busyA) busyCntA++;
    if (doneA) doneCntA++;
    if (busyB) busyCntB++;
    if (doneB) doneCntB++;
  endtask

  task automatic clearCounts();
    busyCntA = 0; doneCntA = 0; busyCntB = 0; doneCntB = 0;
  endtask

  int doneAt;
  bit found;

  initial begin
    mCnt[0] = -1; mCnt[1] = -1;
    mArmed[0] = 1'b0; mArmed[1] = 1'b0;
    mDone[0] = 1'b0; mDone[1] = 1'b0;
    mFrame[0] = '0; mFrame[1] = '0;
    clearCounts();
    rstA = 1'b1; sendA = 1'b0; dataA = 8'h00;
    rstB = 1'b1; sendB = 1'b0; dataB = 8'h00;

    // Reset held 3 cycles with send low, then send kept low: no frame.
    repeat (3) cycle();
    rstA = 1'b0; rstB = 1'b0;
    clearCounts();
    repeat (8) cycle();
    chkInt("no_frame_after_reset_busy", busyCntA + busyCntB, 0);

    // Basic frame 0xA5 on the 4-clock instance.
    dataA = 8'hA5; sendA = 1'b1;
    cycle();
    clearCounts();
    sendA = 1'b0;
    cycle();
    sendA = 1'b1;
    repeat (FLA + 5) cycle();
    chkInt("basic_busy_cycles", busyCntA, 40);
    chkInt("basic_done_pulses", doneCntA, 1);

    // Send held low 100 cycles, data changes after capture.
    dataA = 8'h3C;
    clearCounts();
    sendA = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 5) dataA = 8'hFF;
      cycle();
    end
    chkInt("held_busy_cycles", busyCntA, 40);
    chkInt("held_done_pulses", doneCntA, 1);
    sendA = 1'b1;
    cycle();

    // Back-to-back: release on the done cycle, low again the next cycle.
    dataA = 8'($urandom);
    sendA = 1'b0;
    cycle();
    found = 1'b0;
    for (int c = 0; c < FLA + 5 && !found; c++) begin
      cycle();
      if (doneA) found = 1'b1;
    end
    chkInt("b2b_done_seen", int'(found), 1);
    sendA = 1'b1;
    cycle();
    chk("b2b_gap_tx", txA, 1'b1);
    sendA = 1'b0;
    dataA = 8'($urandom);
    cycle();
    chk("b2b_start_tx", txA, 1'b0);
    chk("b2b_start_busy", busyA, 1'b1);
    repeat (FLA + 2) cycle();
    sendA = 1'b1;
    cycle();

    // Reset mid-frame of 0x81, send kept low through and after reset.
    dataA = 8'h81;
    sendA = 1'b0;
    cycle();
    repeat (14) cycle();
    rstA = 1'b1;
    cycle();
    chk("midrst_tx", txA, 1'b1);
    chk("midrst_busy", busyA, 1'b0);
    chk("midrst_done", doneA, 1'b0);
    rstA = 1'b0;
    clearCounts();
    repeat (10) cycle();
    chkInt("midrst_no_done", doneCntA, 0);
    chkInt("midrst_no_rearm", busyCntA, 0);
    sendA = 1'b1;
    cycle();
    clearCounts();
    sendA = 1'b0;
    cycle();
    sendA = 1'b1;
    repeat (FLA + 3) cycle();
    chkInt("after_rst_frame_busy", busyCntA, 40);
    chkInt("after_rst_frame_done", doneCntA, 1);

    // Reset wins over a simultaneous armed send request.
    rstA = 1'b1; sendA = 1'b0;
    cycle();
    chk("rst_priority_busy", busyA, 1'b0);
    rstA = 1'b0; sendA = 1'b1;
    cycle();

    // Minimum divider: 0x00 with 2 clocks per bit.
    dataB = 8'h00; sendB = 1'b1;
    cycle();
    clearCounts();
    sendB = 1'b0;
    cycle();
    sendB = 1'b1;
    repeat (FLB + 4) cycle();
    chkInt("div2_busy_cycles", busyCntB, 20);
    chkInt("div2_done_pulses", doneCntB, 1);

    // Random traffic on both instances, rare resets.
    for (int c = 0; c < 1500; c++) begin
      sendA = ($urandom_range(0, 3) != 0);
      sendB = ($urandom_range(0, 2) != 0);
      dataA = 8'($urandom);
      dataB = 8'($urandom);
      rstA  = ($urandom_range(0, 299) == 0);
      rstB  = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rstA = 1'b0; rstB = 1'b0; sendA = 1'b1; sendB = 1'b1;
    repeat (FLA + 4) cycle();
    chk("final_idle_txA", txA, 1'b1);
    chk("final_idle_busyA", busyA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
